// File: rtl/pio_key_frontend_if.sv
// Bus bundle between the raw key pins / PIO ports and the key front end.
// The slave modport is the front-end side and the master modport is the system side.
interface pio_key_frontend_if #(
  parameter int unsigned WIDTH = 6
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] ack_in;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] pending_out;
  logic [WIDTH-1:0] press_pulse;

  modport master (
    output raw_in,
    output ack_in,
    input  level_out,
    input  pending_out,
    input  press_pulse
  );

  modport slave (
    input  raw_in,
    input  ack_in,
    output level_out,
    output pending_out,
    output press_pulse
  );
endinterface

// File: rtl/pio_key_frontend.sv
// Key/switch front end for the button PIOs. It synchronises and debounces each raw bit, then
// drives a clean level, a one-cycle press strobe and a sticky pending bit. Firmware clears
// the pending bit by raising the matching ack bit.
// Optional auto-repeat on bits [4:1] is enabled by defining PIO_KEY_FRONTEND_AUTOREPEAT_EN.
module pio_key_frontend #(
  parameter int unsigned WIDTH         = 6,
  parameter int unsigned DB_CYCLES     = 500000,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  pio_key_frontend_if.slave    bus
);

  localparam int unsigned CntW = 24;

  typedef enum logic {StStable0, StStable1} db_state_e;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [1:0]       warm_q;
  logic             sync_ok;
  logic [WIDTH-1:0] sample;

  db_state_e        state_q [WIDTH];
  db_state_e        state_d [WIDTH];
  logic [CntW-1:0]  cnt_q   [WIDTH];
  logic [CntW-1:0]  cnt_d   [WIDTH];
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise, fall;

  logic [WIDTH-1:0] rep_fire;
  logic [WIDTH-1:0] press_now;
  logic [WIDTH-1:0] pulse_q;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] ack_q;
  logic [WIDTH-1:0] ack_edge;

  // Two-flop synchroniser, plus a warm-up shift that marks when sync2_q holds real pin data.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      warm_q  <= '0;
    end else begin
      sync1_q <= bus.raw_in;
      sync2_q <= sync1_q;
      warm_q  <= {warm_q[0], 1'b1};
    end
  end

  // With active-low pins, the zeroed flops would read as "pressed" right after reset.
  // The warm-up flag keeps those samples out of the debounce counters.
  assign sync_ok = warm_q[1];
  assign sample  = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Debounce state register and counters, one FSM per bit.
  always_ff @(posedge clk_clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (reset_reset) begin
        state_q[i] <= StStable0;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Debounce next state: a run of DB_CYCLES differing samples toggles the level.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      rise[i]    = 1'b0;
      fall[i]    = 1'b0;
      if (sync_ok && (sample[i] != (state_q[i] == StStable1))) begin
        if (cnt_q[i] == CntW'(DB_CYCLES - 1)) begin
          if (state_q[i] == StStable0) begin
            state_d[i] = StStable1;
            rise[i]    = 1'b1;
          end else begin
            state_d[i] = StStable0;
            fall[i]    = 1'b1;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Debounce outputs: the level is the FSM state.
  always_comb begin
    level = '0;
    for (int i = 0; i < WIDTH; i++) begin
      level[i] = (state_q[i] == StStable1);
    end
  end

`ifdef PIO_KEY_FRONTEND_AUTOREPEAT_EN
  localparam int unsigned RepW = 25;

  logic [RepW-1:0]  rep_cnt_q   [WIDTH];
  logic [RepW-1:0]  rep_cnt_d   [WIDTH];
  logic [WIDTH-1:0] rep_first_q, rep_first_d;

  // Auto-repeat counters, cleared by reset.
  always_ff @(posedge clk_clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (reset_reset) begin
        rep_cnt_q[i] <= '0;
      end else begin
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
    if (reset_reset) begin
      rep_first_q <= '0;
    end else begin
      rep_first_q <= rep_first_d;
    end
  end

  // Repeat timing: the first interval is REPEAT_DELAY from the press, later ones are REPEAT_PERIOD.
  always_comb begin
    rep_fire    = '0;
    rep_first_d = rep_first_q;
    for (int i = 0; i < WIDTH; i++) begin
      rep_cnt_d[i] = '0;
      if (i >= 1 && i <= 4) begin
        if (rise[i]) begin
          rep_first_d[i] = 1'b1;
        end else if (level[i] && !fall[i]) begin
          if (rep_cnt_q[i] == (rep_first_q[i] ? RepW'(REPEAT_DELAY - 1)
                                              : RepW'(REPEAT_PERIOD - 1))) begin
            rep_fire[i]    = 1'b1;
            rep_first_d[i] = 1'b0;
          end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
          end
        end else begin
          rep_first_d[i] = 1'b0;
        end
      end else begin
        rep_first_d[i] = 1'b0;
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

  assign press_now = rise | rep_fire;
  assign ack_edge  = bus.ack_in & ~ack_q;

  // Strobe and pending registers. A press in the same cycle as an ack edge wins.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pulse_q   <= '0;
      pending_q <= '0;
      ack_q     <= '0;
    end else begin
      pulse_q   <= press_now;
      pending_q <= press_now | (pending_q & ~ack_edge);
      ack_q     <= bus.ack_in;
    end
  end

  assign bus.level_out   = level;
  assign bus.press_pulse = pulse_q;
  assign bus.pending_out = pending_q;

endmodule

// File: tb/tb_pio_key_frontend.sv
// Directed bench for pio_key_frontend with DB_CYCLES=4 and active-low keys.
// Cycle k means the state sampled on the negedge after the k-th rising edge that follows
// the input change.
module tb_pio_key_frontend;
  localparam int unsigned W = 6;

  logic clk_clk = 1'b0;
  logic reset_reset;
  int   checks   = 0;
  int   failures = 0;

  pio_key_frontend_if #(.WIDTH(W)) bus ();

  pio_key_frontend #(
    .WIDTH        (W),
    .DB_CYCLES    (4),
    .ACTIVE_LOW   (1'b1),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .bus        (bus.slave)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] lvl, input logic [W-1:0] pend,
                         input logic [W-1:0] pul);
    chk({tag, "_level"}, bus.level_out, lvl);
    chk({tag, "_pending"}, bus.pending_out, pend);
    chk({tag, "_pulse"}, bus.press_pulse, pul);
  endtask

  task automatic tick();
    @(negedge clk_clk);
  endtask

  initial begin
    logic [W-1:0] exp_pul;

    // Reset and idle with all keys released.
    reset_reset = 1'b1;
    bus.raw_in  = 6'h3F;
    bus.ack_in  = 6'h00;
    repeat (3) tick();
    chk_all("reset", 6'h00, 6'h00, 6'h00);
    reset_reset = 1'b0;
    repeat (8) tick();
    chk_all("idle", 6'h00, 6'h00, 6'h00);

    // Clean press of bit 0: level, pulse and pending all appear at cycle 6.
    bus.raw_in = 6'h3E;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all($sformatf("press_c%0d", k), (k >= 6) ? 6'h01 : 6'h00,
              (k >= 6) ? 6'h01 : 6'h00, (k == 6) ? 6'h01 : 6'h00);
    end

    // A three-cycle glitch on bit 3 must be ignored.
    bus.raw_in = 6'h36;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk_all($sformatf("glitch_c%0d", k), 6'h01, 6'h01, 6'h00);
      if (k == 3) bus.raw_in = 6'h3E;
    end

    // Releasing bit 0 drops the level but produces no pulse and keeps pending.
    bus.raw_in = 6'h3F;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all($sformatf("release_c%0d", k), (k >= 6) ? 6'h00 : 6'h01, 6'h01, 6'h00);
    end

    // Holding ack clears pending once. A new press during the hold sets it again at cycle 8.
    bus.ack_in = 6'h01;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_all($sformatf("ackhold_c%0d", k), (k >= 8) ? 6'h01 : 6'h00,
              (k >= 8) ? 6'h01 : 6'h00, (k == 8) ? 6'h01 : 6'h00);
      if (k == 2) bus.raw_in = 6'h3E;
    end
    bus.ack_in = 6'h00;
    tick();
    bus.ack_in = 6'h01;
    tick();
    chk("ack_clear2", bus.pending_out, 6'h00);
    bus.ack_in = 6'h00;
    tick();

    // Collision: the ack edge on bit 1 lands on the press edge, so pending stays set.
    bus.raw_in = 6'h3C;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all($sformatf("collide_c%0d", k), (k >= 6) ? 6'h03 : 6'h01,
              (k >= 6) ? 6'h02 : 6'h00, (k == 6) ? 6'h02 : 6'h00);
      if (k == 5) bus.ack_in = 6'h02;
    end
    bus.ack_in = 6'h00;
    tick();

    // An ack on a bit that is not pending changes nothing.
    bus.ack_in = 6'h10;
    tick();
    tick();
    chk("ack_idle_bit", bus.pending_out, 6'h02);
    bus.ack_in = 6'h00;
    tick();

    // Reset two cycles into a press on bit 5. Bits 0, 1 and 5 then debounce together.
    bus.raw_in = 6'h1C;
    tick();
    tick();
    reset_reset = 1'b1;
    tick();
    tick();
    chk_all("rst_hold", 6'h00, 6'h00, 6'h00);
    reset_reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all($sformatf("rst_rel_c%0d", k), (k >= 6) ? 6'h23 : 6'h00,
              (k >= 6) ? 6'h23 : 6'h00, (k == 6) ? 6'h23 : 6'h00);
    end

    // Release everything and clear pending.
    bus.raw_in = 6'h3F;
    repeat (8) tick();
    bus.ack_in = 6'h3F;
    tick();
    bus.ack_in = 6'h00;
    tick();
    chk_all("rep_idle", 6'h00, 6'h00, 6'h00);

    // Long hold on bit 2; the release is seen at cycle 30.
    bus.raw_in = 6'h3B;
    for (int k = 1; k <= 34; k++) begin
      tick();
`ifdef PIO_KEY_FRONTEND_AUTOREPEAT_EN
      exp_pul = (k == 6 || k == 16 || k == 21 || k == 26) ? 6'h04 : 6'h00;
`else
      exp_pul = (k == 6) ? 6'h04 : 6'h00;
`endif
      chk_all($sformatf("hold_c%0d", k), (k >= 6 && k < 30) ? 6'h04 : 6'h00,
              (k >= 6) ? 6'h04 : 6'h00, exp_pul);
      if (k == 24) bus.raw_in = 6'h3F;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
